// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall bus layout, stall masks and controller state encodings
package pipe_ctrl_pkg;

  localparam int StallBusMsb = 5;

  localparam int StallPc  = 0;
  localparam int StallIf  = 1;
  localparam int StallId  = 2;
  localparam int StallEx  = 3;
  localparam int StallMem = 4;
  localparam int StallWb  = 5;

  // ex stall freezes pc..ex while mem/wb drain; decode stall freezes pc..id
  localparam logic [StallBusMsb:0] StallMaskNone = 6'b000000;
  localparam logic [StallBusMsb:0] StallMaskEx   = 6'b001111;
  localparam logic [StallBusMsb:0] StallMaskId   = 6'b000111;

  localparam logic FlushEnable = 1'b1;

  typedef enum logic [1:0] {
    CtrlIdle   = 2'd0,
    CtrlMcRun  = 2'd1,
    CtrlMcDone = 2'd2,
    CtrlFlush  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_mc_down_counter.sv
// rtl/pipe_ctrl_mc_down_counter.sv - loadable decrement counter with an is_one flag
module pipe_ctrl_mc_down_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline controller merging decode stalls, multi-cycle execute and flush redirects
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id_i,
  input  logic                   mc_start_i,
  input  logic [CNT_W-1:0]       mc_cycles_i,
  input  logic                   flush_req_i,
  input  logic [31:0]            flush_pc_i,
  output logic [StallBusMsb:0]   stall_o,
  output logic                   flush_o,
  output logic [31:0]            new_pc_o,
  output logic                   mc_busy_o,
  output logic                   mc_done_o
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_next;
  logic             w_load;
  logic             w_dec;
  logic             w_is_one;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic [31:0]      r_new_pc;
  logic             w_ex_stall;

  // a zero-cycle request still needs one run cycle so the done pulse has a slot
  assign w_load_val = (mc_cycles_i == '0) ? CNT_W'(1) : mc_cycles_i;

  pipe_ctrl_mc_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (w_load_val),
    .o_cnt      (w_cnt),
    .o_is_one   (w_is_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CtrlIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      CtrlIdle: begin
        if (flush_req_i) begin
          w_state_next = CtrlFlush;
        end else if (mc_start_i) begin
          w_state_next = CtrlMcRun;
          w_load       = 1'b1;
        end
      end
      CtrlMcRun: begin
        if (flush_req_i) begin
          w_state_next = CtrlFlush;
        end else if (w_is_one) begin
          w_state_next = CtrlMcDone;
        end else begin
          w_dec = 1'b1;
        end
      end
      CtrlMcDone: w_state_next = flush_req_i ? CtrlFlush : CtrlIdle;
      CtrlFlush:  w_state_next = flush_req_i ? CtrlFlush : CtrlIdle;
      default:    w_state_next = CtrlIdle;
    endcase
  end

  // every state moves to FLUSH on a request, so the target is captured unconditionally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_pc <= '0;
    end else if (flush_req_i) begin
      r_new_pc <= flush_pc_i;
    end
  end

  assign w_ex_stall = (r_state == CtrlMcRun) || ((r_state == CtrlIdle) && mc_start_i);

  always_comb begin
    stall_o = StallMaskNone;
    if (rst || (r_state == CtrlFlush) || flush_req_i) begin
      stall_o = StallMaskNone;
    end else if (w_ex_stall) begin
      stall_o = StallMaskEx;
    end else if (stallreq_id_i) begin
      stall_o = StallMaskId;
    end
  end

  assign flush_o   = (r_state == CtrlFlush) ? FlushEnable : 1'b0;
  assign new_pc_o  = r_new_pc;
  assign mc_busy_o = (r_state == CtrlMcRun);
  assign mc_done_o = (r_state == CtrlMcDone);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id_i;
  logic        mc_start_i;
  logic [5:0]  mc_cycles_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
  logic        mc_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .mc_start_i    (mc_start_i),
    .mc_cycles_i   (mc_cycles_i),
    .flush_req_i   (flush_req_i),
    .flush_pc_i    (flush_pc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .mc_busy_o     (mc_busy_o),
    .mc_done_o     (mc_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id_i = 1'b0;
    mc_start_i    = 1'b0;
    mc_cycles_i   = '0;
    flush_req_i   = 1'b0;
    flush_pc_i    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stallreq_id_i = 1'b1;
    mc_start_i = 1'b1;
    mc_cycles_i = 6'd4;
    flush_req_i = 1'b1;
    flush_pc_i = 32'hDEAD_BEEF;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got %b exp %b", stall_o, 6'b000000); end
    n_checks++;
    if ({flush_o, mc_busy_o, mc_done_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {flush_o, mc_busy_o, mc_done_o}); end
    n_checks++;
    if (new_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc got %h exp %h", new_pc_o, 32'h0); end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL post_reset_stall got %b exp %b", stall_o, 6'b000000); end
    step();
    @(negedge clk);
    n_checks++;
    if ({flush_o, mc_busy_o, mc_done_o, new_pc_o} !== 35'h0) begin n_fail++; $display("FAIL post_reset_idle got %b/%b/%b/%h exp 0/0/0/0", flush_o, mc_busy_o, mc_done_o, new_pc_o); end
  endtask

  task automatic test_stall_id();
    step();
    stallreq_id_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000111) begin n_fail++; $display("FAIL id_stall got %b exp %b", stall_o, 6'b000111); end
    step();
    stallreq_id_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL id_stall_release got %b exp %b", stall_o, 6'b000000); end
    n_checks++;
    if ({flush_o, mc_busy_o, mc_done_o} !== 3'b000) begin n_fail++; $display("FAIL id_stall_nostate got %b exp 000", {flush_o, mc_busy_o, mc_done_o}); end
  endtask

  // op started at k=0 with stallreq held through k=N; stallreq drops for the done cycle
  task automatic test_mc(input logic [5:0] cycles, input int n);
    step();
    mc_start_i = 1'b1;
    mc_cycles_i = cycles;
    stallreq_id_i = 1'b1;
    for (int k = 0; k <= n + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (stall_o !== ((k <= n) ? 6'b001111 : 6'b000000)) begin
        n_fail++; $display("FAIL mc%0d_stall k=%0d got %b exp %b", cycles, k, stall_o, (k <= n) ? 6'b001111 : 6'b000000);
      end
      n_checks++;
      if (mc_busy_o !== (k >= 1 && k <= n)) begin
        n_fail++; $display("FAIL mc%0d_busy k=%0d got %b exp %b", cycles, k, mc_busy_o, (k >= 1 && k <= n));
      end
      n_checks++;
      if (mc_done_o !== (k == n + 1)) begin
        n_fail++; $display("FAIL mc%0d_done k=%0d got %b exp %b", cycles, k, mc_done_o, (k == n + 1));
      end
      step();
      mc_start_i = (k + 1 <= n);
      mc_cycles_i = 6'd9;
      stallreq_id_i = (k + 1 <= n);
    end
    idle_inputs();
  endtask

  task automatic test_flush_abort();
    step();
    mc_start_i = 1'b1;
    mc_cycles_i = 6'd5;
    step();
    mc_start_i = 1'b0;
    step();
    flush_req_i = 1'b1;
    flush_pc_i = 32'h0000_0040;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL abort_stall_t2 got %b exp %b", stall_o, 6'b000000); end
    n_checks++;
    if (mc_busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy_t2 got %b exp 1", mc_busy_o); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1) begin n_fail++; $display("FAIL abort_flush_t3 got %b exp 1", flush_o); end
    n_checks++;
    if (new_pc_o !== 32'h40) begin n_fail++; $display("FAIL abort_new_pc got %h exp %h", new_pc_o, 32'h40); end
    n_checks++;
    if ({mc_busy_o, mc_done_o, stall_o} !== 8'h00) begin n_fail++; $display("FAIL abort_t3_quiet got %b/%b/%b exp 0/0/000000", mc_busy_o, mc_done_o, stall_o); end
    for (int k = 4; k <= 9; k++) begin
      step();
      @(negedge clk);
      n_checks++;
      if ({flush_o, mc_busy_o, mc_done_o} !== 3'b000) begin
        n_fail++; $display("FAIL abort_after k=%0d flush/busy/done got %b exp 000", k, {flush_o, mc_busy_o, mc_done_o});
      end
    end
  endtask

  task automatic test_back_to_back();
    step();
    flush_req_i = 1'b1;
    flush_pc_i = 32'h100;
    step();
    flush_pc_i = 32'h200;
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h100) begin n_fail++; $display("FAIL b2b_first got %b/%h exp 1/%h", flush_o, new_pc_o, 32'h100); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h200) begin n_fail++; $display("FAIL b2b_second got %b/%h exp 1/%h", flush_o, new_pc_o, 32'h200); end
    step();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b0 || new_pc_o !== 32'h200) begin n_fail++; $display("FAIL b2b_hold got %b/%h exp 0/%h", flush_o, new_pc_o, 32'h200); end
  endtask

  task automatic test_flush_wins();
    step();
    mc_start_i = 1'b1;
    mc_cycles_i = 6'd3;
    flush_req_i = 1'b1;
    flush_pc_i = 32'h0000_0300;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL win_stall got %b exp %b", stall_o, 6'b000000); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1 || mc_busy_o !== 1'b0 || new_pc_o !== 32'h300) begin
      n_fail++; $display("FAIL win_flush got %b/%b/%h exp 1/0/%h", flush_o, mc_busy_o, new_pc_o, 32'h300);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({flush_o, mc_busy_o, mc_done_o} !== 3'b000) begin n_fail++; $display("FAIL win_idle got %b exp 000", {flush_o, mc_busy_o, mc_done_o}); end
  endtask

  task automatic test_reset_mid_op();
    step();
    mc_start_i = 1'b1;
    mc_cycles_i = 6'd8;
    step();
    mc_start_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mc_busy_o, mc_done_o, stall_o} !== 8'h00) begin n_fail++; $display("FAIL rst_mid_op got %b/%b/%b exp 0/0/000000", mc_busy_o, mc_done_o, stall_o); end
    n_checks++;
    if (new_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_new_pc got %h exp %h", new_pc_o, 32'h0); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_stall_id();
    test_mc(6'd3, 3);
    test_mc(6'd0, 1);
    test_flush_abort();
    test_back_to_back();
    test_flush_wins();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage core. It merges stall requests from decode with a multi-cycle execute sequencer and exception/redirect flush requests, then drives one stall vector and one flush strobe to `pc_reg`, `if_id`, `id_ex`, `ex_mem` and `mem_wb`. It is instantiated once in the core top, beside the pipeline registers it controls.

## Interface
Parameters:
- `CNT_W`, 6: width of the multi-cycle count; the maximum run is 2^CNT_W−1 cycles.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `stallreq_id_i` in 1: decode hazard request (load-use).
- `mc_start_i` in 1: execute begins a multi-cycle op (mult/div) this cycle.
- `mc_cycles_i` in CNT_W: extra cycles the op needs; 0 is treated as 1.
- `flush_req_i` in 1: flush request from mem (exception/redirect).
- `flush_pc_i` in 32: redirect target, sampled with `flush_req_i`.
- `stall_o` out 6: stall mask. Bit [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.
- `flush_o` out 1: one-cycle flush strobe to all pipeline registers.
- `new_pc_o` out 32: redirect PC, valid while `flush_o`=1.
- `mc_busy_o` out 1: the sequencer is in MC_RUN.
- `mc_done_o` out 1: one-cycle pulse telling execute its result is final.

## Operation
- FSM states: IDLE, MC_RUN, MC_DONE, FLUSH. The counter `cnt` is CNT_W bits.
- IDLE:
  - If `flush_req_i`: go to FLUSH and latch `new_pc_o` ← `flush_pc_i`.
  - Otherwise, if `mc_start_i`: go to MC_RUN with `cnt` ← max(`mc_cycles_i`, 1).
- MC_RUN:
  - `flush_req_i` has priority: go to FLUSH. The op is abandoned and no `mc_done_o` pulse is produced.
  - Otherwise, if `cnt`==1: go to MC_DONE. Otherwise decrement `cnt`.
  - `mc_start_i` is ignored in this state.
- MC_DONE:
  - `mc_done_o`=1.
  - `flush_req_i` goes to FLUSH. Otherwise go to IDLE. A fresh `mc_start_i` is honoured only from IDLE, on the next cycle.
- FLUSH:
  - `flush_o`=1.
  - `flush_req_i` again: stay in FLUSH and re-latch `new_pc_o`. Otherwise go to IDLE.
- `stall_o` is combinational from state and inputs, evaluated in priority order:
  1. `rst` or state FLUSH or `flush_req_i`: 6'b000000.
  2. MC_RUN, or IDLE with `mc_start_i`: 6'b001111 (ex stalls; mem and wb drain).
  3. `stallreq_id_i`: 6'b000111.
  4. Otherwise: 6'b000000.
- `stallreq_id_i` is masked while an ex stall is active.
- `mc_busy_o` = (state==MC_RUN). `flush_o` and `mc_done_o` are decoded from state.
- `new_pc_o` holds its last latched value outside FLUSH.

## Timing
- Reset (synchronous): state=IDLE, `cnt`=0, `new_pc_o`=0. All outputs are 0 (`stall_o`=0, `flush_o`=0, `mc_busy_o`=0, `mc_done_o`=0).
- A reset asserted in any state returns to IDLE on the next edge. Any in-progress op or flush is dropped.
- Multi-cycle op, `mc_start_i` at cycle T with N = max(`mc_cycles_i`, 1):
  - `stall_o`[3:0] is high in cycles T through T+N (N+1 cycles).
  - `mc_busy_o` is high in cycles T+1 through T+N.
  - `mc_done_o` pulses at T+N+1, with `stall_o`=0.
- Flush, `flush_req_i` at cycle T:
  - `stall_o`=0 in cycle T.
  - `flush_o`=1 and `new_pc_o` are valid in cycle T+1.
- Stall paths have zero latency. Flush has one cycle of latency.
- Simultaneous `mc_start_i` and `flush_req_i` in IDLE: the flush wins and the op never starts.

## Structure
- Add to `define.vh`:
  - `StallBus` (5:0).
  - Stall bit indices `StallPc`..`StallWb`.
  - State encodings `CtrlIdle`, `CtrlMcRun`, `CtrlMcDone`, `CtrlFlush`.
  - `FlushEnable`.
- One sub-module is natural: `mc_down_counter`, a loadable decrement counter with an `is_one` flag.
- The FSM, stall decode and PC latch stay in `pipe_ctrl`.

## Test plan
- Reset with `flush_req_i`=1 and `mc_start_i`=1 applied → all outputs 0. Release reset → IDLE, `stall_o`=0.
- `stallreq_id_i`=1 for 1 cycle in IDLE → `stall_o`=6'b000111 in that same cycle and 0 the next. No state change.
- `mc_start_i` with `mc_cycles_i`=3 at T:
  - `stall_o`=6'b001111 for T..T+3.
  - `mc_busy_o` high for T+1..T+3.
  - `mc_done_o` pulses at T+4.
  - An asserted `stallreq_id_i` is masked throughout.
- `mc_cycles_i`=0 at T → behaves as 1: stall for T..T+1, `mc_done_o` at T+2.
- Start a 5-cycle op, then `flush_req_i` with `flush_pc_i`=32'h0000_0040 at T+2:
  - `stall_o`=0 at T+2.
  - `flush_o`=1 and `new_pc_o`=32'h40 at T+3.
  - `mc_done_o` never pulses. IDLE at T+4.
- `flush_req_i` on two consecutive cycles with PCs 32'h100 then 32'h200 → `flush_o` high for 2 cycles, and `new_pc_o` reads 32'h100 then 32'h200.
